// File: rtl/trng_pkg.sv
// Shared definitions for the von Neumann TRNG packer: state encoding and
// default parameter values used by the top and its health-test sub-module.
package trng_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_RCT_CUTOFF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PENDING = 2'd2,
    ST_FAIL    = 2'd3
  } trng_state_e;

endpackage

// File: rtl/trng_health_rct.sv
// Repetition count test on the raw entropy stream. The run counter restarts
// at 1 on a value change and counts up on a repeat; fail is a combinational
// strobe on the sampling edge where the run reaches RCT_CUTOFF.
module trng_health_rct
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic sample,
  input  logic sample_valid,
  output logic fail
);

  localparam int unsigned CW = $clog2(RCT_CUTOFF + 1);
  localparam logic [CW-1:0] CUTOFF = CW'(RCT_CUTOFF);

  logic [CW-1:0] run_q, run_d;
  logic          last_q, last_d;

  // Next run length; saturates at the cutoff so it never wraps.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    fail   = 1'b0;
    if (clear) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (sample_valid) begin
      last_d = sample;
      if ((run_q == '0) || (sample != last_q)) begin
        run_d = CW'(1);
      end else if (run_q != CUTOFF) begin
        run_d = run_q + CW'(1);
      end
      fail = (run_d == CUTOFF);
    end
  end

  // Run counter and last-sample registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/trng_vn_packer.sv
// Von Neumann debiaser and byte packer. Raw oscillator samples are paired,
// debiased bits are shifted in MSB-first, and each completed word is offered
// to a downstream FIFO. A repetition count test guards the raw stream.
//
// FIFO handshake: wr_en is high while a word is PENDING and fifo_full is low;
// the FIFO takes data_out on every rising edge where wr_en=1, and the block
// returns to COLLECT on that same edge. fifo_full=1 stalls indefinitely.
module trng_vn_packer
  import trng_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  raw_bit,
  input  logic                  raw_valid,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  health_fail,
  output logic                  overrun,
  output logic [15:0]           byte_cnt,
  output trng_state_e           state_dbg
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  trng_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  half_q, half_d;
  logic                  first_q, first_d;
  logic                  hf_q, hf_d;
  logic                  ovr_q, ovr_d;
  logic [15:0]           byte_cnt_q, byte_cnt_d;

  logic                  samp_ok;
  logic                  vn_valid;
  logic                  vn_bit;
  logic [DATA_WIDTH-1:0] new_word;
  logic                  rct_clear;
  logic                  rct_fail;

  // The health test only watches samples taken while actively collecting.
  assign rct_clear = !enable || (state_q == ST_IDLE) || (state_q == ST_FAIL);

  trng_health_rct #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (rct_clear),
    .sample      (raw_bit),
    .sample_valid(raw_valid),
    .fail        (rct_fail)
  );

  assign wr_en       = (state_q == ST_PENDING) && !fifo_full;
  assign data_out    = data_q;
  assign health_fail = hf_q;
  assign overrun     = ovr_q;
  assign byte_cnt    = byte_cnt_q;
  assign state_dbg   = state_q;

  // Pairing, packing and state transitions.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    half_d     = half_q;
    first_d    = first_q;
    hf_d       = hf_q;
    ovr_d      = ovr_q;
    byte_cnt_d = byte_cnt_q;
    vn_valid   = 1'b0;
    vn_bit     = 1'b0;
    new_word   = '0;

    samp_ok = enable && raw_valid &&
              ((state_q == ST_COLLECT) || (state_q == ST_PENDING));

    // Von Neumann pair: 01 -> 0, 10 -> 1, i.e. the first bit of an unequal pair.
    if (samp_ok) begin
      if (!half_q) begin
        half_d  = 1'b1;
        first_d = raw_bit;
      end else begin
        half_d  = 1'b0;
        first_d = 1'b0;
        if (first_q != raw_bit) begin
          vn_valid = 1'b1;
          vn_bit   = first_q;
        end
      end
    end

    if (wr_en) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end

    if (!enable) begin
      state_d   = ST_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      half_d    = 1'b0;
      first_d   = 1'b0;
      if (state_q == ST_FAIL) begin
        hf_d  = 1'b0;
        ovr_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          half_d  = 1'b0;
          first_d = 1'b0;
          state_d = ST_COLLECT;
        end
        ST_COLLECT, ST_PENDING: begin
          if (rct_fail) begin
            state_d   = ST_FAIL;
            hf_d      = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
            half_d    = 1'b0;
            first_d   = 1'b0;
          end else begin
            if (vn_valid) begin
              if (state_q == ST_COLLECT) begin
                new_word = {shift_q[DATA_WIDTH-2:0], vn_bit};
                if (bit_cnt_q == LAST_BIT) begin
                  data_d    = new_word;
                  shift_d   = '0;
                  bit_cnt_d = '0;
                  state_d   = ST_PENDING;
                end else begin
                  shift_d   = new_word;
                  bit_cnt_d = bit_cnt_q + BW'(1);
                end
              end else begin
                ovr_d = 1'b1;
              end
            end
            if (wr_en) begin
              state_d = ST_COLLECT;
            end
          end
        end
        default: begin
          half_d  = 1'b0;
          first_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      half_q     <= 1'b0;
      first_q    <= 1'b0;
      hf_q       <= 1'b0;
      ovr_q      <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      half_q     <= half_d;
      first_q    <= first_d;
      hf_q       <= hf_d;
      ovr_q      <= ovr_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed bench for trng_vn_packer with a queue-based reference model and a
// per-cycle compare process.
module tb_trng_vn_packer;
  import trng_pkg::*;

  localparam int W   = 8;
  localparam int RCT = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic          raw_bit = 1'b0;
  logic          raw_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic          wr_en;
  logic [W-1:0]  data_out;
  logic          health_fail;
  logic          overrun;
  logic [15:0]   byte_cnt;
  trng_state_e   state_dbg;

  trng_vn_packer #(.DATA_WIDTH(W), .RCT_CUTOFF(RCT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .health_fail(health_fail),
    .overrun    (overrun),
    .byte_cnt   (byte_cnt),
    .state_dbg  (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debiased bits are kept as a list; a word is formed by plain arithmetic
  // once the list holds W entries.
  trng_state_e m_state = ST_IDLE;
  bit          m_bits[$];
  int          m_half = -1;
  int          m_run  = 0;
  bit          m_last = 1'b0;
  logic [W-1:0] m_byte = '0;
  logic [15:0] m_cnt  = '0;
  bit          m_hf   = 1'b0;
  bit          m_ovr  = 1'b0;

  task automatic model_step();
    bit wr;
    bit got;
    bit vb;
    if (!reset_n) begin
      m_state = ST_IDLE; m_bits.delete(); m_half = -1; m_run = 0; m_last = 0;
      m_byte = '0; m_cnt = '0; m_hf = 0; m_ovr = 0;
      return;
    end
    wr = (m_state == ST_PENDING) && !fifo_full;
    if (wr) m_cnt = m_cnt + 16'd1;
    if (!enable) begin
      if (m_state == ST_FAIL) begin m_hf = 0; m_ovr = 0; end
      m_state = ST_IDLE; m_bits.delete(); m_half = -1; m_run = 0;
      return;
    end
    if (m_state == ST_IDLE) begin m_state = ST_COLLECT; return; end
    if (m_state == ST_FAIL) return;
    got = 0; vb = 0;
    if (raw_valid) begin
      if (m_run == 0 || raw_bit != m_last) m_run = 1; else m_run = m_run + 1;
      m_last = raw_bit;
      if (m_run >= RCT) begin
        m_state = ST_FAIL; m_hf = 1; m_bits.delete(); m_half = -1;
        return;
      end
      if (m_half < 0) m_half = int'(raw_bit);
      else begin
        if (m_half != int'(raw_bit)) begin got = 1; vb = (m_half == 1); end
        m_half = -1;
      end
    end
    if (got) begin
      if (m_state == ST_COLLECT) begin
        m_bits.push_back(vb);
        if (m_bits.size() == W) begin
          int v = 0;
          foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
          m_byte = W'(v);
          m_bits.delete();
          m_state = ST_PENDING;
        end
      end else begin
        m_ovr = 1;
      end
    end
    if (wr) m_state = ST_COLLECT;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_wr;
    exp_wr = (m_state == ST_PENDING) && !fifo_full;
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("state", 32'(state_dbg), 32'(m_state));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    if (exp_wr) chk("data_out", 32'(data_out), 32'(m_byte));
    if (wr_en === 1'b1) pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    tick(1);
    raw_valid = 1'b0;
  endtask

  task automatic send_pair(input logic a, input logic b);
    samp(a);
    samp(b);
  endtask

  // Sends one unequal pair per bit of v, MSB first.
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_pair(v[i], ~v[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] vb;
    // reset state
    tick(3);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst data_out", 32'(data_out), 32'd0);
    chk("rst byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(1);
    chk("enter collect", 32'(state_dbg), 32'(ST_COLLECT));

    // pairs 10,01,10,10,01,01,10,01 -> 0xB2, wr_en the cycle after completion
    send_pair(1,0); send_pair(0,1); send_pair(1,0); send_pair(1,0);
    send_pair(0,1); send_pair(0,1); send_pair(1,0); send_pair(0,1);
    chk("b2 wr_en", 32'(wr_en), 32'd1);
    chk("b2 data", 32'(data_out), 32'hB2);
    tick(1);
    chk("b2 byte_cnt", 32'(byte_cnt), 32'd1);
    chk("b2 wr_en low", 32'(wr_en), 32'd0);
    chk("b2 pulses", 32'(pulses), 32'd1);

    // same byte with 00/11 pairs interleaved
    vb = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      send_pair(vb[i], ~vb[i]);
      if (i % 2 == 0) send_pair(0,0); else send_pair(1,1);
    end
    tick(1);
    chk("interleave byte_cnt", 32'(byte_cnt), 32'd2);
    chk("interleave pulses", 32'(pulses), 32'd2);

    // stalled FIFO: completed byte held, extra debiased bit sets overrun
    fifo_full = 1'b1;
    send_byte(8'h5A);
    chk("stall state", 32'(state_dbg), 32'(ST_PENDING));
    chk("stall wr_en", 32'(wr_en), 32'd0);
    send_pair(1,0);
    chk("overrun set", 32'(overrun), 32'd1);
    tick(4);
    chk("stall hold data", 32'(data_out), 32'h5A);
    fifo_full = 1'b0;
    #1;
    chk("release wr_en", 32'(wr_en), 32'd1);
    chk("release data", 32'(data_out), 32'h5A);
    tick(1);
    chk("release byte_cnt", 32'(byte_cnt), 32'd3);
    chk("release pulses", 32'(pulses), 32'd3);

    // 32 consecutive ones trip the repetition count test
    for (int i = 0; i < RCT - 1; i++) samp(1'b1);
    chk("rct before cutoff", 32'(health_fail), 32'd0);
    samp(1'b1);
    chk("rct health_fail", 32'(health_fail), 32'd1);
    chk("rct state", 32'(state_dbg), 32'(ST_FAIL));
    send_pair(1,0);
    chk("fail ignores", 32'(pulses), 32'd3);
    enable = 1'b0;
    tick(1);
    chk("fail exit hf", 32'(health_fail), 32'd0);
    chk("fail exit ovr", 32'(overrun), 32'd0);
    chk("fail exit state", 32'(state_dbg), 32'(ST_IDLE));

    // partial byte discarded on disable; sample at the disable edge ignored
    enable = 1'b1;
    tick(1);
    send_pair(1,0); send_pair(0,1); send_pair(1,0); send_pair(0,1); send_pair(1,0);
    samp(1'b1);
    enable = 1'b0;
    samp(1'b0);
    enable = 1'b1;
    tick(1);
    send_byte(8'hFF);
    chk("ff wr_en", 32'(wr_en), 32'd1);
    chk("ff data", 32'(data_out), 32'hFF);
    tick(1);
    chk("ff byte_cnt", 32'(byte_cnt), 32'd4);

    // reset while PENDING loses the byte
    fifo_full = 1'b1;
    send_byte(8'hC3);
    chk("pend data", 32'(data_out), 32'hC3);
    reset_n = 1'b0;
    #1;
    chk("rst pend wr_en", 32'(wr_en), 32'd0);
    chk("rst pend data", 32'(data_out), 32'd0);
    chk("rst pend byte_cnt", 32'(byte_cnt), 32'd0);
    fifo_full = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6);
    chk("rst no write", 32'(pulses), 32'd4);
    chk("rst collect", 32'(state_dbg), 32'(ST_COLLECT));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trng_vn_packer.md
TRNG_VN_PACKER -- requirements
Module: trng_vn_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the assembled output word.
REQ-002 Parameter RCT_CUTOFF, default 32: consecutive identical raw bits that trip the health failure.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = run; 0 = return to IDLE, discarding partial data.
REQ-006 raw_bit  input  1  raw entropy sample from the oscillator sampler.
REQ-007 raw_valid  input  1  raw_bit is sampled on an edge where raw_valid=1.
REQ-008 fifo_full  input  1  full flag of the downstream 8-bit FIFO.
REQ-009 wr_en  output  1  FIFO write strobe, asserted for exactly one cycle per byte.
REQ-010 data_out  output  DATA_WIDTH  byte presented to the FIFO, valid whenever wr_en=1.
REQ-011 health_fail  output  1  sticky repetition-count failure flag.
REQ-012 overrun  output  1  sticky flag: debiased bit dropped while a byte was pending.
REQ-013 byte_cnt  output  16  count of bytes written (wr_en pulses), wraps 0xFFFF->0.

Function
REQ-014 The block SHALL have the states IDLE, COLLECT, PENDING and FAIL.
REQ-015 IDLE->COLLECT on enable=1; any state->IDLE on enable=0, except FAIL, which also exits only via enable=0.
REQ-016 Von Neumann pairing: the first raw sample is latched; the second completes the pair; 01 yields debiased 0, 10 yields 1, 00/11 yield nothing.
REQ-017 The pair latch SHALL operate in COLLECT and PENDING; it is cleared in IDLE and FAIL.
REQ-018 In COLLECT, debiased bits shift in MSB-first (first bit lands in data_out[DATA_WIDTH-1]).
REQ-019 On the edge producing the DATA_WIDTH-th bit, the full byte SHALL load into the data_out register, the bit counter clears, and the state goes to PENDING.
REQ-020 wr_en SHALL be combinational: (state==PENDING) && !fifo_full.
REQ-021 On an edge with wr_en=1, the state SHALL go PENDING->COLLECT and byte_cnt increments by 1.
REQ-022 Minimum latency: wr_en high in the cycle immediately after the completing edge when fifo_full=0.
REQ-023 Debiased bits produced while in PENDING SHALL be discarded and SHALL set overrun.
REQ-024 While fifo_full=1 in PENDING, data_out SHALL hold its value and wr_en SHALL stay 0 indefinitely.
REQ-025 Repetition count test on every raw sample in COLLECT/PENDING, including unpaired samples: a run counter restarts at 1 on a value change and increments on a repeat.
REQ-026 When the run counter reaches RCT_CUTOFF, the state SHALL go to FAIL on that edge, health_fail is set, and the pending byte is discarded.
REQ-027 In FAIL, wr_en=0 and all samples are ignored.
REQ-028 On leaving FAIL via enable=0, health_fail, overrun, the run counter, the pair latch and the bit counter SHALL clear.
REQ-029 Entering IDLE SHALL discard any partial byte, half-pair and pending byte; byte_cnt is preserved.
REQ-030 raw_valid simultaneous with enable falling SHALL be ignored.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE and zero all registers: data_out=0, health_fail=0, overrun=0, byte_cnt=0, run/bit counters and pair latch = 0.
REQ-032 As a consequence of REQ-020 and REQ-031, wr_en SHALL be 0 during reset.
REQ-033 Reset mid-PENDING or mid-FAIL SHALL lose the held byte with no write issued.

Structure
REQ-034 Shared package trng_pkg SHALL hold the state enumeration and the defaults for DATA_WIDTH and RCT_CUTOFF.
REQ-035 The repetition-count test SHALL be the sub-module trng_health_rct.
- Inputs: clk, reset_n, clear, sample, sample_valid.
- Output: fail.

Verification
REQ-036 Pairs 10,01,10,10,01,01,10,01 with fifo_full=0 -> one wr_en pulse, data_out=8'hB2, byte_cnt=1.
REQ-037 Pairs 00,11,00,11 interleaved with scenario REQ-036 -> same single byte 8'hB2, no extra wr_en.
REQ-038 fifo_full=1 at byte completion, then pair 10 -> wr_en=0 and overrun=1; release fifo_full -> one wr_en pulse with data_out unchanged.
REQ-039 32 consecutive raw_bit=1 samples -> health_fail=1 on the 32nd sampling edge and no wr_en; enable=0 for one cycle -> health_fail=0, state IDLE.
REQ-040 Drop enable after 5 debiased bits, then re-enable with pairs giving 0xFF -> data_out=8'hFF, with no bits from the first attempt.
REQ-041 Assert reset_n=0 in PENDING -> wr_en=0, data_out=0 and byte_cnt=0 immediately; no write after release.
